jellyvl_cdc_handshake_receiver: RTL and testbench
=================================================

// Module: jellyvl_cdc_handshake_receiver
// PURPOSE
//  Destination-side responder for the CDC handshake channel in external-handshake mode (DEST_EXT_HSK=1).
//  - Sits entirely in dest_clk.
//  - Samples dest_req/dest_out, captures each word into a small FIFO and returns dest_ack (4-phase).
//  - Presents captured words as a valid/ready stream.
//  - While the FIFO is full, dest_ack is withheld, so the source side is back-pressured.
// PARAMETERS
//  WIDTH      4  data width; matches the CDC channel WIDTH
//  FIFO_PTR   2  log2 of FIFO depth (0..4); depth = 2**FIFO_PTR entries (1..16)
// PORTS
//  clk       in   1           dest_clk domain clock
//  rst       in   1           asynchronous reset, active-low
//  dest_req  in   1           request from CDC channel, already synchronized to clk
//  dest_in   in   WIDTH       channel data (dest_out of CDC); stable while dest_req=1
//  dest_ack  out  1           acknowledge to CDC channel
//  m_data    out  WIDTH       stream data, FIFO head
//  m_valid   out  1           stream valid
//  m_ready   in   1           stream ready
//  m_count   out  FIFO_PTR+1  FIFO fill level, 0..2**FIFO_PTR
// BEHAVIOUR
//  Reset (rst=0, async), all registers cleared:
//  - dest_ack=0, m_valid=0, m_count=0, m_data=0, state=IDLE, pointers=0.
//  FSM states: IDLE, ACK.
//  - IDLE: dest_ack=0.
//    - If dest_req=1 and m_count<depth: write dest_in at that edge, go to ACK.
//    - If dest_req=1 and FIFO full: remain in IDLE; no write.
//    - Full is evaluated on the registered m_count. A pop in the same cycle does not allow a write;
//      capture happens the next cycle.
//  - ACK: dest_ack=1 (registered, high from the cycle after capture).
//    - Stay in ACK while dest_req=1.
//    - When dest_req=0: return to IDLE; dest_ack=0 from the next cycle.
//    - dest_req seen high again only after this drop starts a new transfer.
//  Exactly one FIFO write per request: level detect in IDLE, edge-equivalent by construction.
//  Latency: dest_req sampled 1 at edge t (IDLE, not full) ->
//  - dest_ack=1 at t+1;
//  - m_valid=1 at t+1 if the FIFO was empty;
//  - m_data=word at t+1 (FIFO head is registered/fall-through).
//  Stream:
//  - Pop when m_valid&&m_ready.
//  - m_data/m_valid are held stable while m_valid&&!m_ready.
//  - m_valid = (m_count!=0).
//  Simultaneous write and pop: m_count unchanged; both pointers advance.
//  Pointers: FIFO_PTR bits, wrap modulo depth.
//  - m_count = FIFO_PTR+1 bits, never exceeds depth, never underflows.
//  - FIFO_PTR=0: single register, count 0/1.
//  dest_in is sampled only at the capture edge; changes at other times are ignored.
//  Reset mid-transfer:
//  - dest_ack drops immediately (async); FIFO contents are discarded.
//  - If dest_req is still 1 after reset release, it is treated as a new request and captured.
//  - The system must reset both CDC ends together.
// TESTING
//  1 Reset values: assert rst=0 with dest_req=1 -> dest_ack=0, m_valid=0, m_count=0 during and after reset.
//  2 Single transfer, m_ready=1:
//    - dest_in=4'hA, dest_req 0->1 at edge t -> dest_ack=1 and m_valid=1/m_data=A at t+1;
//    - dest_req->0 -> dest_ack=0 next cycle; exactly one beat delivered.
//  3 Fill (FIFO_PTR=2, m_ready=0): send 1,2,3,4 -> m_count=4.
//    - 5th req (word 5) held with dest_ack=0.
//    - Raise m_ready for 1 cycle -> 5 captured the cycle after the pop.
//    - Output order 1,2,3,4,5.
//  4 Simultaneous write and pop at count=2 -> count stays 2; data order preserved across pointer wrap (20 words, random m_ready).
//  5 Long dest_req high (10 cycles) -> single capture; dest_ack held 1 until dest_req=0.
//  6 Async reset asserted in ACK state with 3 words queued -> dest_ack=0 and m_count=0 immediately; next request delivered normally.

Source files
------------

// File: rtl/jellyvl_cdc_handshake_receiver.sv
// -----------------------------------------------------------------------------
// jellyvl_cdc_handshake_receiver
//
// Destination-side responder for a 4-phase CDC handshake channel. Runs wholly
// in the destination clock domain. Each request is captured into a small FIFO
// and acknowledged. Captured words leave as a valid/ready stream. While the
// FIFO is full the acknowledge is withheld, so the source side is held back.
//
// Parameters
//   WIDTH     data width, matches the CDC channel
//   FIFO_PTR  log2 of FIFO depth (0..4); depth = 2**FIFO_PTR
//
// Ports
//   clk       destination clock
//   rst       asynchronous reset, active-low
//   dest_req  request from the CDC channel, already synchronised to clk
//   dest_in   channel data, stable while dest_req=1
//   dest_ack  acknowledge back to the CDC channel
//   m_data    stream data (FIFO head, fall-through)
//   m_valid   stream valid
//   m_ready   stream ready
//   m_count   FIFO fill level, 0..2**FIFO_PTR
// -----------------------------------------------------------------------------
module jellyvl_cdc_handshake_receiver #(
  parameter int WIDTH    = 4,
  parameter int FIFO_PTR = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dest_req,
  input  logic [WIDTH-1:0]    dest_in,
  output logic                dest_ack,
  output logic [WIDTH-1:0]    m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [FIFO_PTR:0]   m_count
);

  localparam int DEPTH = 1 << FIFO_PTR;
  // A depth-1 FIFO still needs a legal (1-bit) pointer; it is simply held at 0.
  localparam int PTR_W = (FIFO_PTR > 0) ? FIFO_PTR : 1;
  localparam logic [FIFO_PTR:0] FULL_COUNT = (FIFO_PTR + 1)'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  logic [0:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (FIFO_PTR == 0) return '0;
    return p + PTR_W'(1);
  endfunction

  // Capture is level-detected in IDLE only. Leaving IDLE until the request
  // drops makes it behave like an edge detect: one write per request.
  // Full uses the registered count, so a same-cycle pop does not open a slot.
  assign do_push = (state == IDLE) && dest_req && (m_count != FULL_COUNT);
  assign do_pop  = m_valid && m_ready;

  assign m_valid  = (m_count != '0);
  assign m_data   = mem[rd_ptr];
  assign dest_ack = (state == ACK);

  // Handshake FSM
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (do_push)   state <= ACK;
        ACK:     if (!dest_req) state <= IDLE;
        default:                state <= IDLE;
      endcase
    end
  end

  // FIFO storage
  // NOTE: the storage array is reset on purpose: it is tiny, and m_data reads
  // the array directly, so it must come out of reset as zero, not X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= dest_in;
    end
  end

  // Pointers and fill level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      m_count <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   m_count <= m_count + (FIFO_PTR + 1)'(1);
        2'b01:   m_count <= m_count - (FIFO_PTR + 1)'(1);
        default: m_count <= m_count;
      endcase
    end
  end

endmodule

// File: tb/tb_jellyvl_cdc_handshake_receiver.sv
// -----------------------------------------------------------------------------
// tb_jellyvl_cdc_handshake_receiver
//
// Source-side agent drives 4-phase requests. The expected word is queued when
// a request is issued. A monitor pops the queue on every delivered beat.
// Directed checks cover reset, latency, full back-pressure, simultaneous
// push/pop, long requests and reset in the middle of a transfer.
// -----------------------------------------------------------------------------
module tb_jellyvl_cdc_handshake_receiver;

  localparam int WIDTH    = 4;
  localparam int FIFO_PTR = 2;
  localparam int DEPTH    = 1 << FIFO_PTR;
  localparam int BOUND    = 60;

  logic                clk;
  logic                rst;
  logic                dest_req;
  logic [WIDTH-1:0]    dest_in;
  logic                dest_ack;
  logic [WIDTH-1:0]    m_data;
  logic                m_valid;
  logic                m_ready;
  logic [FIFO_PTR:0]   m_count;

  jellyvl_cdc_handshake_receiver #(.WIDTH(WIDTH), .FIFO_PTR(FIFO_PTR)) dut (
    .clk      (clk),
    .rst      (rst),
    .dest_req (dest_req),
    .dest_in  (dest_in),
    .dest_ack (dest_ack),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_count  (m_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] data_prev = '0;
  always @(negedge clk) begin
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      check("valid_vs_count", 32'(m_valid), 32'(m_count != 0));
      check("count_bound", 32'(m_count <= DEPTH), 32'd1);
      if (hold_prev) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(data_prev));
      end
      if (m_valid && m_ready) begin
        beats++;
        if (exp_q.size() == 0) check("unexpected_beat", 32'(m_data), 32'hdead);
        else check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      hold_prev = m_valid && !m_ready;
      data_prev = m_data;
    end
  end

  task automatic wait_ack(input logic level, input string name);
    int n = 0;
    while (dest_ack !== level && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(dest_ack), 32'(level));
  endtask

  // One complete 4-phase transfer from the source side.
  task automatic send_word(input logic [WIDTH-1:0] w);
    @(posedge clk) #1;
    dest_in  = w;
    dest_req = 1'b1;
    exp_q.push_back(w);
    wait_ack(1'b1, "ack_rise");
    @(posedge clk) #1;
    dest_req = 1'b0;
    dest_in  = WIDTH'($urandom);
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk) #1;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk) #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("drain_count", 32'(m_count), 32'd0);
  endtask

  int  b0;
  logic src_done;

  initial begin
    rst = 1'b0; dest_req = 1'b1; dest_in = 4'h7; m_ready = 1'b0;

    // 1: reset with a request pending
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(dest_ack), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_count", 32'(m_count), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    dest_req = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    check("post_rst_ack", 32'(dest_ack), 32'd0);
    check("post_rst_valid", 32'(m_valid), 32'd0);
    check("post_rst_count", 32'(m_count), 32'd0);

    // 2: single transfer, latency of one cycle
    m_ready = 1'b1;
    b0 = beats;
    @(posedge clk) #1;
    dest_in = 4'hA; dest_req = 1'b1;
    exp_q.push_back(4'hA);
    @(negedge clk);
    check("t2_ack_before", 32'(dest_ack), 32'd0);
    check("t2_valid_before", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t2_ack", 32'(dest_ack), 32'd1);
    check("t2_valid", 32'(m_valid), 32'd1);
    check("t2_data", 32'(m_data), 32'hA);
    @(posedge clk) #1;
    dest_req = 1'b0;
    @(negedge clk);
    check("t2_ack_hold", 32'(dest_ack), 32'd1);
    @(negedge clk);
    check("t2_ack_drop", 32'(dest_ack), 32'd0);
    repeat (3) @(negedge clk);
    check("t2_one_beat", 32'(beats - b0), 32'd1);

    // 3: fill, back-pressure, release by one pop
    @(posedge clk) #1;
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_word(WIDTH'(i));
    @(negedge clk);
    check("t3_full", 32'(m_count), 32'd4);
    @(posedge clk) #1;
    dest_in = 4'h5; dest_req = 1'b1;
    exp_q.push_back(4'h5);
    repeat (4) begin
      @(negedge clk);
      check("t3_ack_withheld", 32'(dest_ack), 32'd0);
    end
    check("t3_still_full", 32'(m_count), 32'd4);
    @(posedge clk) #1;
    m_ready = 1'b1;
    @(posedge clk) #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("t3_no_write_on_pop", 32'(dest_ack), 32'd0);
    check("t3_count_after_pop", 32'(m_count), 32'd3);
    @(negedge clk);
    check("t3_captured", 32'(dest_ack), 32'd1);
    check("t3_refilled", 32'(m_count), 32'd4);
    @(posedge clk) #1;
    dest_req = 1'b0;
    wait_ack(1'b0, "t3_ack_fall");
    drain();

    // 4: simultaneous write and pop at count 2
    send_word(4'hC);
    send_word(4'hD);
    @(posedge clk) #1;
    dest_in = 4'hE; dest_req = 1'b1; m_ready = 1'b1;
    exp_q.push_back(4'hE);
    @(posedge clk) #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("t4_count_steady", 32'(m_count), 32'd2);
    check("t4_ack", 32'(dest_ack), 32'd1);
    @(posedge clk) #1;
    dest_req = 1'b0;
    wait_ack(1'b0, "t4_ack_fall");

    // 4b: 20 random words with random ready, across pointer wrap
    src_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_word(WIDTH'($urandom));
        src_done = 1'b1;
      end
      begin
        while (!src_done) begin
          @(posedge clk) #1;
          m_ready = $urandom_range(0, 1) == 1;
        end
      end
    join
    drain();

    // 5: long request -> single capture, ack held
    m_ready = 1'b1;
    b0 = beats;
    @(posedge clk) #1;
    dest_in = 4'h9; dest_req = 1'b1;
    exp_q.push_back(4'h9);
    wait_ack(1'b1, "t5_ack_rise");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1;
      dest_in = WIDTH'($urandom);
      @(negedge clk);
      check("t5_ack_held", 32'(dest_ack), 32'd1);
    end
    @(posedge clk) #1;
    dest_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_ack_drop", 32'(dest_ack), 32'd0);
    repeat (2) @(negedge clk);
    check("t5_one_beat", 32'(beats - b0), 32'd1);

    // 6: async reset in ACK with 3 words queued
    @(posedge clk) #1;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_word(WIDTH'(i + 10));
    @(posedge clk) #1;
    dest_in = 4'hF; dest_req = 1'b1;
    wait_ack(1'b1, "t6_ack_rise");
    @(posedge clk) #2;
    rst = 1'b0;
    #1;
    check("t6_ack_async", 32'(dest_ack), 32'd0);
    check("t6_count_async", 32'(m_count), 32'd0);
    check("t6_valid_async", 32'(m_valid), 32'd0);
    exp_q.delete();
    dest_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    b0 = beats;
    send_word(4'h6);
    drain();
    check("t6_one_beat", 32'(beats - b0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
